add: RTL and testbench
======================

Name: add

Overview:
- Signed two-operand adder for the datapath accumulator path: adds signed operand `acc` and signed operand `arg1`.
- Produces an exact, full-precision combinational sum `out`, one bit wider than the operands.
- Also provides a saturated operand-width result and an overflow flag.
- Registered copies of these results are provided for downstream pipelined consumers.

Parameters:
- W, 11, operand width in bits (two's complement); `out` is W+1 bits.

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst  input  1  asynchronous, active-high reset; clears registered outputs
- acc  input  W  signed operand A (two's complement)
- arg1  input  W  signed operand B (two's complement)
- out  output  W+1  signed full-precision sum acc+arg1, combinational
- sat_out  output  W  signed sum clamped to the W-bit range, combinational
- ovf  output  1  high when the exact sum does not fit in W signed bits, combinational
- out_q  output  W+1  registered `out`
- sat_q  output  W  registered `sat_out`
- ovf_q  output  1  registered `ovf`

Behaviour:
- One clock (`clk`); reset `rst` is asynchronous and active-high.
- `out`:
  - `out` = sign_extend(acc) + sign_extend(arg1), both extended to W+1 bits before adding.
  - Purely combinational, zero latency, independent of `clk`/`rst`.
  - Result is exact for all input pairs; no wrap is possible.
  - Range for W=11: −2048 … +2046.
- `ovf`:
  - `ovf` = 1 iff `out` > 2^(W−1)−1 or `out` < −2^(W−1).
  - For W=11 the bounds are > 1023 or < −1024.
  - Equivalently, `ovf` = `out`[W] XOR `out`[W−1].
- `sat_out`:
  - Equals `out`[W−1:0] when `ovf`=0.
  - When `ovf`=1 with a positive sum, equals +2^(W−1)−1 (1023).
  - When `ovf`=1 with a negative sum, equals −2^(W−1) (−1024).
  - Sign of the sum is `out`[W].
- Combinational outputs settle within one propagation delay of any input change; they must contain no latches.
- Registered outputs:
  - On each rising `clk` edge with `rst`=0: `out_q` ← `out`, `sat_q` ← `sat_out`, `ovf_q` ← `ovf`.
  - Latency is exactly one cycle.
- Reset:
  - While `rst`=1, `out_q`=0, `sat_q`=0, `ovf_q`=0 immediately, without waiting for a clock edge.
  - On `rst` deassertion, the first rising edge captures the current sum.
  - Reset asserted mid-stream discards the held value.
  - Combinational outputs are unaffected by `rst`.
- Boundary cases:
  - Mixed-sign operands can never overflow.
  - 0 + 0 gives 0 on all outputs.
  - Operand −1024 is valid input.
  - −1024 + −1024 = −2048 with `ovf`=1 and `sat_out`=−1024.
- All arithmetic is signed; the implementation must not rely on unsigned extension.

Test Plan:
- Same-sign, overflowing operands:
  - acc=900, arg1=900 → `out`=1800, `ovf`=1, `sat_out`=1023.
  - acc=−900, arg1=−105 → `out`=−1005, `ovf`=0, `sat_out`=−1005.
  - acc=900, arg1=105 → `out`=1005, `ovf`=0.
- Small and mixed-sign operands:
  - acc=−50, arg1=−50 → `out`=−100.
  - acc=50, arg1=50 → `out`=100.
  - acc=−25, arg1=27 → `out`=2.
  - acc=−27, arg1=25 → `out`=−2.
  - `ovf`=0 for all of these.
- Extremes:
  - acc=1023, arg1=1023 → `out`=2046, `ovf`=1, `sat_out`=1023.
  - acc=−1024, arg1=−1024 → `out`=−2048, `ovf`=1, `sat_out`=−1024.
  - acc=1023, arg1=−1024 → `out`=−1, `ovf`=0.
- Pipeline:
  - Apply acc=900, arg1=105, then one rising `clk` → `out_q`=1005, `sat_q`=1005, `ovf_q`=0.
  - Change inputs to −25/27 → `out_q` holds 1005 until the next edge, then becomes 2.
- Async reset:
  - Assert `rst` between clock edges while `out_q`=1005 → `out_q`, `sat_q`, `ovf_q` go to 0 immediately, and `out` keeps tracking the inputs.
  - Deassert `rst` → the next edge loads the current sum.

Source files
------------

// File: rtl/add.sv
// Signed two-operand adder: exact W+1-bit sum, saturated W-bit sum and overflow flag,
// each also provided as a one-cycle registered copy for pipelined consumers.
module add #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] acc,
   input  logic [W-1:0] arg1,
   output logic [W:0]   out,
   output logic [W-1:0] sat_out,
   output logic         ovf,
   output logic [W:0]   out_q,
   output logic [W-1:0] sat_q,
   output logic         ovf_q
);

   // Both operands are sign-extended to W+1 bits, so the sum can never wrap.
   logic [W:0] a_ext;
   logic [W:0] b_ext;
   logic [W:0] sum;
   logic [W:0] carry;

   assign a_ext    = {acc[W-1], acc};
   assign b_ext    = {arg1[W-1], arg1};
   assign carry[0] = 1'b0;

   // Ripple-carry chain; the carry out of the top bit is not needed.
   for (genvar gi = 0; gi <= W; gi++) begin : g_bit
      assign sum[gi] = a_ext[gi] ^ b_ext[gi] ^ carry[gi];
      if (gi < W) begin : g_carry
         assign carry[gi+1] = (a_ext[gi] & b_ext[gi]) |
                              (carry[gi] & (a_ext[gi] ^ b_ext[gi]));
      end
   end

   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0] sat_next;
   logic         ovf_next;

   // Sum leaves the W-bit range exactly when the two top bits disagree.
   always_comb begin
      ovf_next = sum[W] ^ sum[W-1];
      sat_next = sum[W-1:0];
      if (ovf_next) begin
         sat_next = sum[W] ? SAT_MIN : SAT_MAX;
      end
   end

   assign out     = sum;
   assign sat_out = sat_next;
   assign ovf     = ovf_next;

   logic [W:0]   out_reg;
   logic [W-1:0] sat_reg;
   logic         ovf_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg <= '0;
         sat_reg <= '0;
         ovf_reg <= 1'b0;
      end else begin
         out_reg <= sum;
         sat_reg <= sat_next;
         ovf_reg <= ovf_next;
      end
   end

   assign out_q = out_reg;
   assign sat_q = sat_reg;
   assign ovf_q = ovf_reg;

endmodule

// File: tb/tb_add.sv
// Directed-vector bench for add: combinational sums, saturation, overflow,
// one-cycle pipeline latency and asynchronous reset behaviour.
module tb_add;

   localparam int W = 11;

   logic         clk;
   logic         rst;
   logic [W-1:0] acc;
   logic [W-1:0] arg1;
   logic [W:0]   out;
   logic [W-1:0] sat_out;
   logic         ovf;
   logic [W:0]   out_q;
   logic [W-1:0] sat_q;
   logic         ovf_q;

   int n_checks = 0;
   int n_errors = 0;

   add #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .acc     (acc),
      .arg1    (arg1),
      .out     (out),
      .sat_out (sat_out),
      .ovf     (ovf),
      .out_q   (out_q),
      .sat_q   (sat_q),
      .ovf_q   (ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   function automatic int s_out(input logic [W:0] v);
      return int'($signed(v));
   endfunction

   function automatic int s_sat(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   typedef struct {
      int a;
      int b;
      int sum;
      int sat;
      int ov;
   } vec_t;

   // Hand-computed expected values.
   vec_t vecs [0:10] = '{
      '{  900,   900,  1800,  1023, 1},
      '{ -900,  -105, -1005, -1005, 0},
      '{  900,   105,  1005,  1005, 0},
      '{  -50,   -50,  -100,  -100, 0},
      '{   50,    50,   100,   100, 0},
      '{  -25,    27,     2,     2, 0},
      '{  -27,    25,    -2,    -2, 0},
      '{ 1023,  1023,  2046,  1023, 1},
      '{-1024, -1024, -2048, -1024, 1},
      '{ 1023, -1024,    -1,    -1, 0},
      '{    0,     0,     0,     0, 0}
   };

   initial begin
      rst  = 1'b1;
      acc  = '0;
      arg1 = '0;
      #1;
      check("reset out_q", s_out(out_q), 0);
      check("reset sat_q", s_sat(sat_q), 0);
      check("reset ovf_q", int'(ovf_q), 0);

      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         acc  = W'(vecs[i].a);
         arg1 = W'(vecs[i].b);
         #1;
         check($sformatf("out %0d+%0d", vecs[i].a, vecs[i].b), s_out(out), vecs[i].sum);
         check($sformatf("sat %0d+%0d", vecs[i].a, vecs[i].b), s_sat(sat_out), vecs[i].sat);
         check($sformatf("ovf %0d+%0d", vecs[i].a, vecs[i].b), int'(ovf), vecs[i].ov);
      end

      // Registered overflow case
      @(negedge clk);
      acc  = W'(900);
      arg1 = W'(900);
      @(posedge clk);
      #1;
      check("pipe out_q 1800", s_out(out_q), 1800);
      check("pipe sat_q 1023", s_sat(sat_q), 1023);
      check("pipe ovf_q 1", int'(ovf_q), 1);

      // One-cycle latency and hold
      @(negedge clk);
      acc  = W'(900);
      arg1 = W'(105);
      @(posedge clk);
      #1;
      check("pipe out_q 1005", s_out(out_q), 1005);
      check("pipe sat_q 1005", s_sat(sat_q), 1005);
      check("pipe ovf_q 0", int'(ovf_q), 0);
      acc  = W'(-25);
      arg1 = W'(27);
      #1;
      check("hold out_q", s_out(out_q), 1005);
      check("comb out tracks", s_out(out), 2);
      @(posedge clk);
      #1;
      check("pipe out_q 2", s_out(out_q), 2);

      // Asynchronous reset mid-stream
      acc  = W'(900);
      arg1 = W'(105);
      @(posedge clk);
      #1;
      check("pre-rst out_q", s_out(out_q), 1005);
      #2;
      rst = 1'b1;
      #1;
      check("async rst out_q", s_out(out_q), 0);
      check("async rst sat_q", s_sat(sat_q), 0);
      check("async rst ovf_q", int'(ovf_q), 0);
      acc  = W'(50);
      arg1 = W'(50);
      #1;
      check("rst comb out", s_out(out), 100);
      @(posedge clk);
      #1;
      check("rst held out_q", s_out(out_q), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-rst pre-edge", s_out(out_q), 0);
      @(posedge clk);
      #1;
      check("post-rst out_q", s_out(out_q), 100);
      check("post-rst sat_q", s_sat(sat_q), 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
